// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg
// Shared definitions for the cook timer: FSM state encoding, BCD digit
// limits used by the countdown, and the default prescaler length.
package cook_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX         = 4'd9;
    localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

    localparam int TICKS_PER_SEC_DEFAULT = 1000;

endpackage

// File: rtl/cook_timer_sec_prescaler.sv
// sec_prescaler
// Divides clk down to a one-cycle tick once per second of enabled time.
// The count holds while en is low, so a paused cook keeps its partial second.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   en    in   count enable (RUN with magnetron on)
//   clr   in   synchronous clear of the partial second
//   tick  out  high for the cycle in which the count wraps
module sec_prescaler
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Combinational so the decrement lands on the same edge as the wrap.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/cook_timer.sv
// cook_timer
// Keypad-loaded mm:ss countdown for the magnetron control path. Counts down
// once per second while the magnetron is on and raises timer_done at 00:00.
//
//   state | meaning
//   IDLE  | time is 0000, nothing to count
//   SET   | time nonzero, not counting (loaded or paused)
//   RUN   | counting down
//   DONE  | cook completed, timer_done high
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clearn               active-low synchronous clear (highest priority)
//   digit_valid, digit   keypad strobe and BCD key value
//   mag_on               magnetron state from the magnetron controller
//   timer_done, running  registered status (DONE / RUN)
//   min_tens..sec_ones   registered BCD display digits
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic       timer_done,
    output logic       running,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    state_t      state_q;
    logic [15:0] time_q;
    logic        tick;
    logic        digit_accept;
    logic [15:0] time_shifted;
    logic [15:0] time_dec;

    // Seconds may hold 60-99 as entered; they simply count down from there.
    // Only a borrow out of seconds reloads sec_tens to 5.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        mt = t[15:12];
        mo = t[11:8];
        st = t[7:4];
        so = t[3:0];
        if (t != 16'h0000) begin
            if (so != 4'd0) begin
                so = so - 4'd1;
            end else begin
                so = BCD_MAX;
                if (st != 4'd0) begin
                    st = st - 4'd1;
                end else begin
                    st = SEC_TENS_RELOAD;
                    if (mo != 4'd0) begin
                        mo = mo - 4'd1;
                    end else begin
                        mo = BCD_MAX;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign digit_accept = digit_valid && !mag_on && (digit <= BCD_MAX);
    assign time_shifted = {time_q[11:0], digit};
    assign time_dec     = bcd_dec(time_q);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == ST_RUN) && mag_on),
        .clr (!clearn || digit_accept),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            time_q     <= 16'h0000;
            timer_done <= 1'b0;
            running    <= 1'b0;
        end else if (!clearn) begin
            state_q    <= ST_IDLE;
            time_q     <= 16'h0000;
            timer_done <= 1'b0;
            running    <= 1'b0;
        end else if (digit_accept) begin
            time_q     <= time_shifted;
            state_q    <= (time_shifted != 16'h0000) ? ST_SET : ST_IDLE;
            timer_done <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Magnetron on with nothing loaded: finish at once so it drops.
                    if (mag_on) begin
                        state_q    <= ST_DONE;
                        timer_done <= 1'b1;
                    end
                end
                ST_SET: begin
                    if (mag_on) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!mag_on) begin
                        state_q <= ST_SET;
                        running <= 1'b0;
                    end else if (tick) begin
                        time_q <= time_dec;
                        if (time_dec == 16'h0000) begin
                            state_q    <= ST_DONE;
                            running    <= 1'b0;
                            timer_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

    assign min_tens = time_q[15:12];
    assign min_ones = time_q[11:8];
    assign sec_tens = time_q[7:4];
    assign sec_ones = time_q[3:0];

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer
// Directed bench for cook_timer with TICKS_PER_SEC = 4. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
module tb_cook_timer;
    import cook_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clearn = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on = 1'b0;
    logic       timer_done;
    logic       running;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    int checks = 0;
    int failures = 0;

    cook_timer #(.TICKS_PER_SEC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit      (digit),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .running    (running),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        step(1);
        digit_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    function automatic logic [31:0] disp();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        #1;
        chk("rst_time", disp(), 32'h0000);
        chk("rst_done", 32'(timer_done), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // 01:30 entry
        key(4'd1);
        key(4'd3);
        key(4'd0);
        chk("key_130", disp(), 32'h0130);
        chk("key_130_state", 32'(dut.state_q), 32'(ST_SET));
        chk("key_130_done", 32'(timer_done), 32'd0);
        chk("key_130_run", 32'(running), 32'd0);

        // 00:02 full countdown
        clear_pulse();
        key(4'd0);
        key(4'd2);
        chk("load_002", disp(), 32'h0002);
        mag_on = 1'b1;
        step(1);
        chk("run_start", 32'(running), 32'd1);
        step(3);
        chk("before_tick1", disp(), 32'h0002);
        step(1);
        chk("tick1", disp(), 32'h0001);
        step(3);
        chk("before_tick2", disp(), 32'h0001);
        chk("before_tick2_done", 32'(timer_done), 32'd0);
        step(1);
        chk("expire_time", disp(), 32'h0000);
        chk("expire_done", 32'(timer_done), 32'd1);
        chk("expire_run", 32'(running), 32'd0);

        // clear from DONE, then mag_on with 0000
        clearn = 1'b0;
        step(1);
        chk("clr_done", 32'(timer_done), 32'd0);
        chk("clr_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("clr_time", disp(), 32'h0000);
        clearn = 1'b1;
        step(1);
        chk("idle_magon_done", 32'(timer_done), 32'd1);
        mag_on = 1'b0;
        step(1);

        // 01:00 -> 00:59, entry from DONE clears timer_done
        key(4'd1);
        chk("done_key_clears", 32'(timer_done), 32'd0);
        key(4'd0);
        key(4'd0);
        chk("load_100", disp(), 32'h0100);
        mag_on = 1'b1;
        step(5);
        chk("borrow_059", disp(), 32'h0059);
        mag_on = 1'b0;
        step(1);
        chk("pause_run", 32'(running), 32'd0);
        chk("pause_state", 32'(dut.state_q), 32'(ST_SET));

        // 01:90 -> 01:89
        clear_pulse();
        key(4'd1);
        key(4'd9);
        key(4'd0);
        mag_on = 1'b1;
        step(5);
        chk("sec90_189", disp(), 32'h0189);
        mag_on = 1'b0;
        step(1);

        // partial second kept over a pause; digit ignored while mag_on
        clear_pulse();
        key(4'd5);
        mag_on = 1'b1;
        step(3);
        chk("partial_a", disp(), 32'h0005);
        mag_on = 1'b0;
        step(10);
        chk("partial_pause", disp(), 32'h0005);
        mag_on = 1'b1;
        step(2);
        chk("partial_b", disp(), 32'h0005);
        key(4'd7);
        chk("partial_tick_digit_ignored", disp(), 32'h0004);
        chk("partial_running", 32'(running), 32'd1);
        mag_on = 1'b0;
        step(1);

        // clear in the same cycle as the final tick
        clear_pulse();
        key(4'd1);
        mag_on = 1'b1;
        step(4);
        chk("pre_clear_tick", disp(), 32'h0001);
        clearn = 1'b0;
        step(1);
        chk("clear_vs_tick_time", disp(), 32'h0000);
        chk("clear_vs_tick_done", 32'(timer_done), 32'd0);
        chk("clear_vs_tick_run", 32'(running), 32'd0);
        mag_on = 1'b0;
        clearn = 1'b1;
        step(1);

        // non-BCD key ignored
        key(4'd3);
        key(4'd12);
        chk("key12_ignored", disp(), 32'h0003);
        chk("key12_state", 32'(dut.state_q), 32'(ST_SET));

        // asynchronous reset while running
        mag_on = 1'b1;
        step(2);
        chk("pre_rst_run", 32'(running), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_run", 32'(running), 32'd0);
        chk("async_rst_time", disp(), 32'h0000);
        chk("async_rst_done", 32'(timer_done), 32'd0);
        mag_on = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
